// File: rtl/rc4_keystream_gen.sv
// rtl/rc4_keystream_gen.sv - RC4 key scheduling plus optional dropN and keystream output
// One state-array access pattern per cycle: INIT, KSA, DROP and GEN each split into compute/swap steps.
module rc4_keystream_gen #(
  parameter int KEY_BYTES = 4,
  parameter int DROP_N    = 0
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   gen_state_arr_i,
  input  logic [8*KEY_BYTES-1:0] key_i,
  input  logic                   out_ready_i,
  output logic [7:0]             out_data_o,
  output logic                   out_valid_o,
  output logic                   sarr_generated_o,
  output logic                   busy_o
);

  typedef enum logic [3:0] {
    IDLE, INIT, KSA_J, KSA_SWAP, DROP_IJ, DROP_SWAP, GEN_IJ, GEN_SWAP, GEN_OUT, HOLD
  } stateT;

  localparam logic [15:0] DROP_LAST = 16'(DROP_N - 1);
  localparam logic [3:0]  KEY_LAST  = 4'(KEY_BYTES - 1);

  stateT       state, nextState;
  logic [7:0]  sArr [256];
  logic [7:0]  keyArr [16];
  logic [7:0]  i, j;
  logic [3:0]  keyIdx;
  logic [15:0] dropCnt;

  logic [7:0]   iNext, sI, sJ, sINext, outIdx;
  logic [127:0] keyPad;

  assign iNext  = i + 8'd1;
  assign sI     = sArr[i];
  assign sJ     = sArr[j];
  assign sINext = sArr[iNext];
  assign outIdx = sI + sJ;
  // Left-align the key so byte k always sits at the same position regardless of KEY_BYTES.
  assign keyPad = 128'(key_i) << (128 - 8 * KEY_BYTES);

  assign busy_o = (state == INIT) || (state == KSA_J) || (state == KSA_SWAP) ||
                  (state == DROP_IJ) || (state == DROP_SWAP);

  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (gen_state_arr_i) begin
      nextState = INIT;
    end else begin
      case (state)
        IDLE:      nextState = IDLE;
        INIT:      if (i == 8'hFF) nextState = KSA_J;
        KSA_J:     nextState = KSA_SWAP;
        KSA_SWAP:  if (i == 8'hFF) nextState = (DROP_N == 0) ? GEN_IJ : DROP_IJ;
                   else            nextState = KSA_J;
        DROP_IJ:   nextState = DROP_SWAP;
        DROP_SWAP: nextState = (dropCnt == DROP_LAST) ? GEN_IJ : DROP_IJ;
        GEN_IJ:    nextState = GEN_SWAP;
        GEN_SWAP:  nextState = GEN_OUT;
        GEN_OUT:   nextState = HOLD;
        HOLD:      if (out_ready_i) nextState = GEN_IJ;
        default:   nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      i                <= '0;
      j                <= '0;
      keyIdx           <= '0;
      dropCnt          <= '0;
      out_data_o       <= '0;
      out_valid_o      <= 1'b0;
      sarr_generated_o <= 1'b0;
    end else if (gen_state_arr_i) begin
      i                <= '0;
      j                <= '0;
      keyIdx           <= '0;
      dropCnt          <= '0;
      out_valid_o      <= 1'b0;
      sarr_generated_o <= 1'b0;
    end else begin
      case (state)
        INIT:  i <= iNext;
        KSA_J: j <= j + sI + keyArr[keyIdx];
        KSA_SWAP: begin
          if (i == 8'hFF) begin
            i      <= '0;
            j      <= '0;
            keyIdx <= '0;
            if (DROP_N == 0) sarr_generated_o <= 1'b1;
          end else begin
            i      <= iNext;
            keyIdx <= (keyIdx == KEY_LAST) ? 4'd0 : keyIdx + 4'd1;
          end
        end
        DROP_IJ, GEN_IJ: begin
          i <= iNext;
          j <= j + sINext;
        end
        DROP_SWAP: begin
          if (dropCnt == DROP_LAST) begin
            dropCnt          <= '0;
            sarr_generated_o <= 1'b1;
          end else begin
            dropCnt <= dropCnt + 16'd1;
          end
        end
        GEN_OUT: begin
          out_data_o  <= sArr[outIdx];
          out_valid_o <= 1'b1;
        end
        HOLD: if (out_ready_i) out_valid_o <= 1'b0;
        default: ;
      endcase
    end
  end

  // S and the latched key carry no reset: INIT and the next start rewrite them.
  always_ff @(posedge clk) begin
    if (n_rst && gen_state_arr_i) begin
      for (int k = 0; k < 16; k++) keyArr[k] <= keyPad[127 - 8*k -: 8];
    end else if (n_rst) begin
      case (state)
        INIT: sArr[i] <= i;
        KSA_SWAP, DROP_SWAP, GEN_SWAP: begin
          sArr[i] <= sJ;
          sArr[j] <= sI;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_keystream_gen.sv
// tb/tb_rc4_keystream_gen.sv - scoreboard bench for rc4_keystream_gen with three parameterisations
// Stream 0: "Key"/DROP_N=0, stream 1: "Wiki"/KEY_BYTES=4, stream 2: "Key"/DROP_N=3.
module tb_rc4_keystream_gen;

  logic        clk = 1'b0;
  logic [2:0]  nRst, start, ready;
  logic [23:0] keyA, keyC;
  logic [31:0] keyB;
  logic [7:0]  data [3];
  logic        valid [3];
  logic        sarr [3];
  logic        busy [3];

  logic [7:0] qA[$], qB[$], qC[$];
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  rc4_keystream_gen #(.KEY_BYTES(3), .DROP_N(0)) dutA (
    .clk(clk), .n_rst(nRst[0]), .gen_state_arr_i(start[0]), .key_i(keyA),
    .out_ready_i(ready[0]), .out_data_o(data[0]), .out_valid_o(valid[0]),
    .sarr_generated_o(sarr[0]), .busy_o(busy[0]));

  rc4_keystream_gen #(.KEY_BYTES(4), .DROP_N(0)) dutB (
    .clk(clk), .n_rst(nRst[1]), .gen_state_arr_i(start[1]), .key_i(keyB),
    .out_ready_i(ready[1]), .out_data_o(data[1]), .out_valid_o(valid[1]),
    .sarr_generated_o(sarr[1]), .busy_o(busy[1]));

  rc4_keystream_gen #(.KEY_BYTES(3), .DROP_N(3)) dutC (
    .clk(clk), .n_rst(nRst[2]), .gen_state_arr_i(start[2]), .key_i(keyC),
    .out_ready_i(ready[2]), .out_data_o(data[2]), .out_valid_o(valid[2]),
    .sarr_generated_o(sarr[2]), .busy_o(busy[2]));

  function automatic int qSize(input int d);
    case (d)
      0:       return qA.size();
      1:       return qB.size();
      default: return qC.size();
    endcase
  endfunction

  task automatic pushExp(input int d, input logic [7:0] v);
    case (d)
      0:       qA.push_back(v);
      1:       qB.push_back(v);
      default: qC.push_back(v);
    endcase
  endtask

  task automatic popCheck(input int d, input logic [7:0] got);
    logic [7:0] exp;
    logic       have;
    exp  = '0;
    have = 1'b0;
    case (d)
      0:       if (qA.size() > 0) begin exp = qA.pop_front(); have = 1'b1; end
      1:       if (qB.size() > 0) begin exp = qB.pop_front(); have = 1'b1; end
      default: if (qC.size() > 0) begin exp = qC.pop_front(); have = 1'b1; end
    endcase
    compared++;
    if (!have) begin
      mismatched++;
      $display("FAIL stream%0d unexpected byte: got %02h, required none", d, got);
    end else if (got !== exp) begin
      mismatched++;
      $display("FAIL stream%0d byte: got %02h, required %02h", d, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++)
      if (nRst[d] && valid[d] && ready[d]) popCheck(d, data[d]);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    compared++;
    if (got !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic pulseStart(input int d);
    @(posedge clk); #1 start[d] = 1'b1;
    @(posedge clk); #1 start[d] = 1'b0;
  endtask

  task automatic waitValid(input int d, input int expLat, input string name);
    int cnt;
    cnt = 0;
    while (!valid[d] && cnt < 2000) begin
      @(posedge clk); #1;
      cnt++;
    end
    check(name, cnt, expLat);
  endtask

  task automatic drain(input int d);
    int cnt;
    cnt = 0;
    while (qSize(d) != 0 && cnt < 400) begin
      @(posedge clk); #1;
      cnt++;
    end
    ready[d] = 1'b0;
    if (qSize(d) != 0) begin
      compared++;
      mismatched++;
      $display("FAIL stream%0d drain timeout: %0d bytes left, required 0", d, qSize(d));
    end
  endtask

  task automatic pushKeyRef(input int n);
    logic [7:0] ref8 [9];
    ref8 = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7};
    for (int k = 0; k < n; k++) pushExp(0, ref8[k]);
  endtask

  initial begin
    int n;
    nRst = '0; start = '0; ready = '0;
    keyA = 24'h4B6579; keyC = 24'h4B6579; keyB = 32'h57696B69;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++)
      check($sformatf("reset outputs %0d", d), {data[d], valid[d], sarr[d], busy[d]}, 32'h0);
    nRst = 3'b111;

    // Stream 0: reference "Key" stream at full rate, exact latency.
    ready[0] = 1'b1;
    pushKeyRef(9);
    pulseStart(0);
    waitValid(0, 771, "key latency");
    drain(0);

    // Stream 0: backpressure for 20 cycles on the first byte.
    pushKeyRef(3);
    pulseStart(0);
    waitValid(0, 771, "bp latency");
    for (int c = 0; c < 20; c++) begin
      check("bp hold", {valid[0], data[0]}, {24'h0, 1'b1, 8'hEB});
      @(posedge clk); #1;
    end
    ready[0] = 1'b1;
    drain(0);

    // Stream 0: reset while a byte is pending, then a clean restart.
    pulseStart(0);
    waitValid(0, 771, "pre-reset latency");
    nRst[0] = 1'b0;
    @(posedge clk); #1;
    check("reset mid-run", {data[0], valid[0], sarr[0], busy[0]}, 32'h0);
    nRst[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle after reset", {valid[0], sarr[0], busy[0]}, 32'h0);
    ready[0] = 1'b1;
    pushKeyRef(4);
    pulseStart(0);
    waitValid(0, 771, "post-reset latency");
    drain(0);

    // Stream 1: "Wiki", busy window, key changes after start are ignored.
    ready[1] = 1'b1;
    pushExp(1, 8'h60); pushExp(1, 8'h44); pushExp(1, 8'hDB); pushExp(1, 8'h6D); pushExp(1, 8'h41);
    pulseStart(1);
    keyB = 32'hDEADBEEF;
    n = 0;
    while (busy[1] && n < 2000) begin
      n++;
      @(posedge clk); #1;
    end
    check("busy cycles", n, 768);
    check("sarr after ksa", {31'h0, sarr[1]}, 32'h1);
    drain(1);

    // Stream 1: restart with "Wiki" at KSA cycle ~400 of a run keyed with junk.
    keyB = 32'h41424344;
    pulseStart(1);
    repeat (655) @(posedge clk);
    #1;
    keyB = 32'h57696B69;
    ready[1] = 1'b1;
    pushExp(1, 8'h60); pushExp(1, 8'h44); pushExp(1, 8'hDB);
    pulseStart(1);
    check("abort sarr/busy", {30'h0, sarr[1], busy[1]}, 32'h1);
    waitValid(1, 771, "abort latency");
    drain(1);

    // Stream 2: drop-3 starts at the fourth reference byte.
    ready[2] = 1'b1;
    pushExp(2, 8'h81); pushExp(2, 8'hB7); pushExp(2, 8'h34);
    pulseStart(2);
    waitValid(2, 777, "drop3 latency");
    drain(2);

    repeat (10) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rc4_keystream_gen.md
RC4_KEYSTREAM_GEN -- requirements
Module: rc4_keystream_gen

Interface
REQ-001 The block SHALL have parameter KEY_BYTES, default 4, giving the key length in bytes (legal range 1..16).
REQ-002 The block SHALL have parameter DROP_N, default 0, giving the number of initial keystream bytes generated and discarded before the first output (RC4-dropN).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-004 The block SHALL have port n_rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port gen_state_arr_i, input, 1 bit: start pulse; latches the key and begins state-array generation.
REQ-006 The block SHALL have port key_i, input, 8*KEY_BYTES bits: key; byte 0 = key_i[8*KEY_BYTES-1 -: 8] (MSB first).
REQ-007 The block SHALL have port out_ready_i, input, 1 bit: downstream accepts out_data_o when high together with out_valid_o.
REQ-008 The block SHALL have port out_data_o, output, 8 bits: keystream byte, held stable while out_valid_o=1 and out_ready_i=0.
REQ-009 The block SHALL have port out_valid_o, output, 1 bit: out_data_o holds an unconsumed keystream byte.
REQ-010 The block SHALL have port sarr_generated_o, output, 1 bit: KSA and drop phase complete, and keystream is being produced.
REQ-011 The block SHALL have port busy_o, output, 1 bit: high in INIT, KSA or DROP.

Function
REQ-012 The block SHALL hold a 256x8 state array S and 8-bit indices i and j; all index arithmetic SHALL be mod 256.
REQ-013 The FSM SHALL have states IDLE, INIT, KSA_J, KSA_SWAP, DROP_IJ, DROP_SWAP, GEN_IJ, GEN_SWAP, GEN_OUT and HOLD.
REQ-014 In IDLE, gen_state_arr_i=1 SHALL latch key_i, clear i and j, and go to INIT.
REQ-015 INIT SHALL write S[i]=i for one index per cycle, taking 256 cycles, then clear i and go to KSA_J.
REQ-016 KSA_J SHALL compute j = j + S[i] + key[i mod KEY_BYTES]; the next cycle, KSA_SWAP SHALL swap S[i] and S[j] and increment i.
REQ-017 KSA SHALL take 512 cycles; after i wraps from 255 to 0, the block SHALL clear i and j and go to DROP_IJ, or to GEN_IJ when DROP_N=0.
REQ-018 Each keystream step SHALL proceed as follows: *_IJ sets i=i+1 and j=j+S[i+1]; *_SWAP swaps S[i] and S[j]; GEN_OUT registers out_data_o = S[(S[i]+S[j]) mod 256] and sets out_valid_o.
REQ-019 DROP SHALL run DROP_N two-cycle steps with no output, using a 16-bit drop counter.
REQ-020 sarr_generated_o SHALL rise on the cycle the FSM first enters GEN_IJ and SHALL stay high until reset or restart.
REQ-021 After GEN_OUT, the FSM SHALL enter HOLD.
REQ-022 In HOLD, out_ready_i=1 SHALL complete the transfer, clear out_valid_o and go to GEN_IJ; otherwise the FSM SHALL stay in HOLD with data frozen. Peak rate is therefore 1 byte per 4 cycles.
REQ-023 The latency from the start pulse to the first out_valid_o SHALL be 256 + 512 + 2*DROP_N + 3 cycles (771 when DROP_N=0).
REQ-024 gen_state_arr_i=1 in any state other than IDLE SHALL abort the current operation, clear out_valid_o, sarr_generated_o, i and j, re-latch key_i, and enter INIT the next cycle.
REQ-025 Key changes on key_i while not starting SHALL be ignored.
REQ-026 out_ready_i SHALL be ignored while out_valid_o=0.
REQ-027 A swap with i==j SHALL leave S unchanged.

Reset
REQ-028 n_rst=0 at a rising edge SHALL force the FSM to IDLE and set i, j, the drop counter, out_data_o, out_valid_o, sarr_generated_o and busy_o to 0.
REQ-029 The contents of S SHALL be don't-care after reset (INIT rewrites them).
REQ-030 Reset SHALL take priority over gen_state_arr_i.
REQ-031 Reset asserted in the middle of an operation SHALL discard all progress.

Verification
REQ-032 A bench SHALL check: KEY_BYTES=3, key "Key", out_ready_i=1 -> bytes EB 9F 77 81 B7 34 CA 72 A7; first out_valid_o exactly 771 cycles after start.
REQ-033 A bench SHALL check: KEY_BYTES=4, key "Wiki" -> 60 44 DB 6D 41; busy_o high for 768 cycles, then sarr_generated_o=1.
REQ-034 A bench SHALL check: key "Key", DROP_N=3 -> first output byte 81; latency 777 cycles.
REQ-035 A bench SHALL check: out_ready_i held low 20 cycles after the first byte -> out_data_o=EB stable throughout, then next byte 9F; no byte lost or duplicated.
REQ-036 A bench SHALL check: gen_state_arr_i pulsed at cycle 400 of KSA with key "Wiki" -> sarr_generated_o=0, fresh 771-cycle latency, stream 60 44 DB...
REQ-037 A bench SHALL check: n_rst=0 while out_valid_o=1 -> all outputs 0 next edge; FSM in IDLE; a new start then reproduces the reference stream.
